branch_resolve: RTL

ID-stage branch control that consumes the equal/not_equal flags from the operand equality comparator. It decides BEQ/BNE/J outcomes and computes the target PC. It drives a one-cycle PC redirect plus IF/ID flush, and stalls ID while the compared operands are still in flight from a load. It also keeps saturating branch statistics and sticky error flags.

---
 rtl/branch_resolve.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/branch_resolve.sv
// ID-stage branch resolver: decides BEQ/BNE/J, stalls on load-use of compared operands,
// issues a one-cycle PC redirect/flush and keeps saturating branch statistics plus sticky errors.
module branch_resolve #(
   parameter int MAX_STALL = 4,
   parameter int CNT_BITS  = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                br_valid,
   input  logic [1:0]          br_op,
   input  logic                operand_busy,
   input  logic                equal,
   input  logic                not_equal,
   input  logic [31:0]         pc_plus4,
   input  logic [31:0]         br_offset,
   input  logic [25:0]         jump_index,
   output logic                stall_id,
   output logic                redirect,
   output logic [31:0]         redirect_pc,
   output logic                flush_if,
   output logic [CNT_BITS-1:0] branch_count,
   output logic [CNT_BITS-1:0] taken_count,
   output logic                hazard_err,
   output logic                cmp_err
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_STALL = 2'd1;
   localparam logic [1:0] S_REDIR = 2'd2;

   localparam logic [1:0] OP_NONE = 2'd0;
   localparam logic [1:0] OP_BEQ  = 2'd1;
   localparam logic [1:0] OP_BNE  = 2'd2;
   localparam logic [1:0] OP_J    = 2'd3;

   localparam int                  SC_W    = $clog2(MAX_STALL + 1);
   localparam logic [SC_W-1:0]     SC_ONE  = SC_W'(1);
   localparam logic [SC_W-1:0]     SC_MAX  = SC_W'(MAX_STALL);
   localparam logic [CNT_BITS-1:0] CNT_ONE = CNT_BITS'(1);

   logic [1:0]          state_q, state_d;
   logic [1:0]          op_q, op_d;
   logic [31:0]         pc_q, pc_d;
   logic [31:0]         off_q, off_d;
   logic [SC_W-1:0]     scnt_q, scnt_d;
   logic [31:0]         redirect_pc_q, redirect_pc_d;
   logic [CNT_BITS-1:0] branch_count_q, branch_count_d;
   logic [CNT_BITS-1:0] taken_count_q, taken_count_d;
   logic                hazard_err_q, hazard_err_d;
   logic                cmp_err_q, cmp_err_d;

   logic        req, decide, taken, stall;
   logic [1:0]  dec_op;
   logic [31:0] dec_pc, dec_off, target;

   always_comb begin
      state_d        = state_q;
      op_d           = op_q;
      pc_d           = pc_q;
      off_d          = off_q;
      scnt_d         = scnt_q;
      redirect_pc_d  = redirect_pc_q;
      branch_count_d = branch_count_q;
      taken_count_d  = taken_count_q;
      hazard_err_d   = hazard_err_q;
      cmp_err_d      = cmp_err_q;
      req            = br_valid && (br_op != OP_NONE);
      decide         = 1'b0;
      stall          = 1'b0;
      dec_op         = br_op;
      dec_pc         = pc_plus4;
      dec_off        = br_offset;

      case (state_q)
         S_IDLE: begin
            if (req) begin
               if (br_op == OP_J || !operand_busy) begin
                  decide = 1'b1;
               end else begin
                  stall   = 1'b1;
                  op_d    = br_op;
                  pc_d    = pc_plus4;
                  off_d   = br_offset;
                  scnt_d  = SC_ONE;
                  state_d = S_STALL;
               end
            end
         end
         S_STALL: begin
            // Only BEQ/BNE ever reach here, so the live jump_index is never used.
            dec_op  = op_q;
            dec_pc  = pc_q;
            dec_off = off_q;
            if (!operand_busy) begin
               decide = 1'b1;
            end else if (scnt_q < SC_MAX) begin
               stall  = 1'b1;
               scnt_d = scnt_q + SC_ONE;
            end else begin
               // Stall budget spent: release ID and drop the branch without counting it.
               hazard_err_d = 1'b1;
               scnt_d       = '0;
               state_d      = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      taken  = (dec_op == OP_J) || (dec_op == OP_BEQ && equal) || (dec_op == OP_BNE && not_equal);
      target = (dec_op == OP_J) ? {dec_pc[31:28], jump_index, 2'b00} : dec_pc + (dec_off << 2);

      if (decide) begin
         scnt_d = '0;
         if (dec_op != OP_J && equal == not_equal)
            cmp_err_d = 1'b1;
         if (branch_count_q != '1)
            branch_count_d = branch_count_q + CNT_ONE;
         if (taken) begin
            if (taken_count_q != '1)
               taken_count_d = taken_count_q + CNT_ONE;
            redirect_pc_d = target;
            state_d       = S_REDIR;
         end else begin
            state_d = S_IDLE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= S_IDLE;
         op_q           <= OP_NONE;
         pc_q           <= '0;
         off_q          <= '0;
         scnt_q         <= '0;
         redirect_pc_q  <= '0;
         branch_count_q <= '0;
         taken_count_q  <= '0;
         hazard_err_q   <= 1'b0;
         cmp_err_q      <= 1'b0;
      end else begin
         state_q        <= state_d;
         op_q           <= op_d;
         pc_q           <= pc_d;
         off_q          <= off_d;
         scnt_q         <= scnt_d;
         redirect_pc_q  <= redirect_pc_d;
         branch_count_q <= branch_count_d;
         taken_count_q  <= taken_count_d;
         hazard_err_q   <= hazard_err_d;
         cmp_err_q      <= cmp_err_d;
      end
   end

   assign stall_id     = stall;
   assign redirect     = (state_q == S_REDIR);
   assign flush_if     = (state_q == S_REDIR);
   assign redirect_pc  = redirect_pc_q;
   assign branch_count = branch_count_q;
   assign taken_count  = taken_count_q;
   assign hazard_err   = hazard_err_q;
   assign cmp_err      = cmp_err_q;

endmodule
